axis_packet_arbiter: RTL and testbench

Round-robin, packet-locked arbiter that merges `NUM_SLAVES` AXI-Stream inputs onto one AXI-Stream output. It sits in front of the shared register pipeline/switch path in the stream interconnect. A requester holds the output from its first accepted beat until its `last` beat is accepted. The output is fully registered with one stage and provides full throughput within a packet.

---
 rtl/axis_arb_pkg.sv | 11 +
 rtl/rr_priority_picker.sv | 26 ++
 rtl/axis_packet_arbiter.sv | 117 +++++++++++
 tb/tb_axis_packet_arbiter.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/axis_arb_pkg.sv
// Shared types and helpers for the AXI-Stream packet arbiter and related switch arbiters.
package axis_arb_pkg;

   typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} arb_state_t;

   // Index width for n requesters, never narrower than one bit.
   function automatic int src_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Circular first-set-bit search: returns the first requester after 'last', wrapping around
// and ending on 'last' itself.
module rr_priority_picker
   import axis_arb_pkg::*;
#(
   parameter int N         = 4,
   parameter int SRC_WIDTH = src_width(N)
) (
   input  logic [N-1:0]         req,
   input  logic [SRC_WIDTH-1:0] last,
   output logic                 any,
   output logic [SRC_WIDTH-1:0] idx
);

   always_comb begin
      any = 1'b0;
      idx = '0;
      for (int k = 1; k <= N; k++) begin
         if (!any && req[(int'(last) + k) % N]) begin
            any = 1'b1;
            idx = SRC_WIDTH'((int'(last) + k) % N);
         end
      end
   end

endmodule

// File: rtl/axis_packet_arbiter.sv
// Round-robin, packet-locked merge of NUM_SLAVES AXI-Stream inputs onto one registered output.
// The winner of an IDLE-cycle arbitration keeps the output until its last beat is accepted.
module axis_packet_arbiter
   import axis_arb_pkg::*;
#(
   parameter int NUM_SLAVES = 4,
   parameter int DATA_WIDTH = 64,
   parameter int DEST_WIDTH = 1,
   parameter int SRC_WIDTH  = src_width(NUM_SLAVES)
) (
   input  logic                            aclk,
   input  logic                            aresetn,
   input  logic [NUM_SLAVES-1:0]           s_valid,
   output logic [NUM_SLAVES-1:0]           s_ready,
   input  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_data,
   input  logic [NUM_SLAVES*DEST_WIDTH-1:0] s_dest,
   input  logic [NUM_SLAVES-1:0]           s_last,
   output logic                            m_valid,
   input  logic                            m_ready,
   output logic [DATA_WIDTH-1:0]           m_data,
   output logic [DEST_WIDTH-1:0]           m_dest,
   output logic                            m_last,
   output logic [SRC_WIDTH-1:0]            m_src
);

   // Handshake: a beat moves on an edge where valid && ready are both high. Valid never waits
   // on ready; the granted s_ready is high whenever the output register is empty or draining.

   arb_state_t             state;
   arb_state_t             state_nxt;
   logic [SRC_WIDTH-1:0]   grant;
   logic [SRC_WIDTH-1:0]   last_grant;
   logic [SRC_WIDTH-1:0]   pick_idx;
   logic                   pick_any;
   logic                   out_full;
   logic                   out_room;
   logic                   sel_valid;
   logic                   sel_last;
   logic [DATA_WIDTH-1:0]  sel_data;
   logic [DEST_WIDTH-1:0]  sel_dest;
   logic                   in_xfer;

   rr_priority_picker #(
      .N         (NUM_SLAVES),
      .SRC_WIDTH (SRC_WIDTH)
   ) u_picker (
      .req  (s_valid),
      .last (last_grant),
      .any  (pick_any),
      .idx  (pick_idx)
   );

   assign sel_valid = s_valid[grant];
   assign sel_last  = s_last[grant];
   assign sel_data  = s_data[grant*DATA_WIDTH +: DATA_WIDTH];
   assign sel_dest  = s_dest[grant*DEST_WIDTH +: DEST_WIDTH];

   assign out_room  = !out_full || m_ready;
   assign in_xfer   = (state == LOCKED) && sel_valid && out_room;
   assign m_valid   = out_full;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (pick_any) state_nxt = LOCKED;
         LOCKED:  if (in_xfer && sel_last) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      s_ready = '0;
      if (state == LOCKED) begin
         s_ready[grant] = out_room;
      end
   end

   // Grants are captured only in IDLE, so the owner cannot change mid-packet.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         grant      <= '0;
         last_grant <= SRC_WIDTH'(NUM_SLAVES - 1);
      end else if (state == IDLE && pick_any) begin
         grant      <= pick_idx;
         last_grant <= pick_idx;
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         out_full <= 1'b0;
      end else if (in_xfer) begin
         out_full <= 1'b1;
      end else if (m_ready) begin
         out_full <= 1'b0;
      end
   end

   // Payload needs no reset: it is only observed while out_full is set.
   always_ff @(posedge aclk) begin
      if (in_xfer) begin
         m_data <= sel_data;
         m_dest <= sel_dest;
         m_last <= sel_last;
         m_src  <= grant;
      end
   end

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// Directed bench for axis_packet_arbiter: per-input beat sources, expected-beat queue,
// cycle-count checks for arbitration bubbles, backpressure and async reset.
module tb_axis_packet_arbiter;

   localparam int NS = 4;
   localparam int DW = 16;
   localparam int EW = 1;
   localparam int SW = 2;
   localparam int W  = SW + 1 + EW + DW;

   logic                aclk = 1'b0;
   logic                aresetn = 1'b0;
   logic [NS-1:0]       s_valid;
   logic [NS-1:0]       s_ready;
   logic [NS*DW-1:0]    s_data;
   logic [NS*EW-1:0]    s_dest;
   logic [NS-1:0]       s_last;
   logic                m_valid;
   logic                m_ready;
   logic [DW-1:0]       m_data;
   logic [EW-1:0]       m_dest;
   logic                m_last;
   logic [SW-1:0]       m_src;

   logic [DW+1:0]       src_mem [NS][32];
   int                  src_rd [NS];
   int                  src_wr [NS];
   logic [W-1:0]        exp_q[$];
   int                  n_pass = 0;
   int                  n_total = 0;

   axis_packet_arbiter #(
      .NUM_SLAVES (NS),
      .DATA_WIDTH (DW),
      .DEST_WIDTH (EW)
   ) dut (
      .aclk    (aclk),
      .aresetn (aresetn),
      .s_valid (s_valid),
      .s_ready (s_ready),
      .s_data  (s_data),
      .s_dest  (s_dest),
      .s_last  (s_last),
      .m_valid (m_valid),
      .m_ready (m_ready),
      .m_data  (m_data),
      .m_dest  (m_dest),
      .m_last  (m_last),
      .m_src   (m_src)
   );

   always #5 aclk = ~aclk;

   function automatic logic [DW-1:0] pkt_data(input int i, input int p, input int b);
      return {4'(i), 4'(p), 8'(8'hA0 + b)};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic drive_inputs();
      for (int i = 0; i < NS; i++) begin
         s_valid[i] = src_rd[i] < src_wr[i];
         {s_last[i], s_dest[i*EW +: EW], s_data[i*DW +: DW]} = src_mem[i][src_rd[i] % 32];
      end
   endtask

   task automatic add_pkt(input int i, input int p, input int len);
      for (int b = 0; b < len; b++) begin
         src_mem[i][src_wr[i] % 32] = {(b == len - 1), 1'(b % 2), pkt_data(i, p, b)};
         src_wr[i]++;
      end
   endtask

   task automatic expect_pkt(input int s, input int p, input int len);
      for (int b = 0; b < len; b++) begin
         exp_q.push_back({2'(s), (b == len - 1), 1'(b % 2), pkt_data(s, p, b)});
      end
   endtask

   task automatic clear_sources();
      for (int i = 0; i < NS; i++) begin
         src_rd[i] = 0;
         src_wr[i] = 0;
      end
   endtask

   // One clock: sample handshakes at negedge, let the edge happen, then advance the sources.
   task automatic step();
      logic [NS-1:0] acc;
      logic [W-1:0]  exp_beat;
      @(negedge aclk);
      acc = s_valid & s_ready;
      check("ready_onehot", 32'($countones(s_ready) <= 1), 32'd1);
      if (m_valid && m_ready) begin
         check("beat_expected", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            exp_beat = exp_q.pop_front();
            check("beat", 32'({m_src, m_last, m_dest, m_data}), 32'(exp_beat));
         end
      end
      @(posedge aclk);
      #1;
      for (int i = 0; i < NS; i++) begin
         if (acc[i]) src_rd[i]++;
      end
      drive_inputs();
   endtask

   task automatic run_pkts(input string tag, input int exp_cyc);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         step();
         n++;
      end
      check({tag, "_cycles"}, 32'(n), 32'(exp_cyc));
   endtask

   initial begin
      m_ready = 1'b1;
      clear_sources();

      // Reset held with every input requesting.
      for (int i = 0; i < NS; i++) begin
         add_pkt(i, 0, 2);
         add_pkt(i, 1, 2);
      end
      drive_inputs();
      repeat (3) @(negedge aclk);
      check("rst_m_valid", 32'(m_valid), 32'd0);
      check("rst_s_ready", 32'(s_ready), 32'd0);
      @(posedge aclk);
      #1;
      aresetn = 1'b1;
      check("idle_s_ready", 32'(s_ready), 32'd0);

      // Rotation: eight 2-beat packets, 3 cycles each plus output latency.
      for (int p = 0; p < 2; p++) begin
         for (int i = 0; i < NS; i++) expect_pkt(i, p, 2);
      end
      run_pkts("rotation", 25);

      // Packet lock: input 0 appears while input 1 is mid-packet.
      add_pkt(1, 2, 4);
      expect_pkt(1, 2, 4);
      drive_inputs();
      step();
      step();
      add_pkt(0, 2, 2);
      expect_pkt(0, 2, 2);
      drive_inputs();
      step();
      check("lock_s_ready", 32'(s_ready), 32'h2);
      run_pkts("lock", 6);

      // Backpressure mid-packet on input 2.
      add_pkt(2, 3, 4);
      expect_pkt(2, 3, 4);
      drive_inputs();
      repeat (3) step();
      m_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         step();
         check("bp_m_valid", 32'(m_valid), 32'd1);
         check("bp_m_data", 32'(m_data), 32'(pkt_data(2, 3, 1)));
         check("bp_m_src", 32'(m_src), 32'd2);
         check("bp_s_ready", 32'(s_ready), 32'd0);
      end
      m_ready = 1'b1;
      run_pkts("bp", 3);

      // Single-beat packets from the lone requester 3; scan wraps back to 3.
      for (int p = 4; p < 7; p++) begin
         add_pkt(3, p, 1);
         expect_pkt(3, p, 1);
      end
      drive_inputs();
      run_pkts("single", 7);

      // Async reset between edges while beat 2 of 4 is pending.
      add_pkt(2, 7, 4);
      expect_pkt(2, 7, 4);
      drive_inputs();
      repeat (3) step();
      #2;
      aresetn = 1'b0;
      #1;
      check("arst_m_valid", 32'(m_valid), 32'd0);
      check("arst_s_ready", 32'(s_ready), 32'd0);
      exp_q.delete();
      clear_sources();
      drive_inputs();
      @(posedge aclk);
      #1;
      aresetn = 1'b1;
      check("post_rst_m_valid", 32'(m_valid), 32'd0);

      // After reset input 1 must win over input 3.
      add_pkt(3, 8, 1);
      add_pkt(1, 8, 1);
      expect_pkt(1, 8, 1);
      expect_pkt(3, 8, 1);
      drive_inputs();
      run_pkts("post_rst", 5);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
